// File: rtl/tb_doutb_xbar.sv
// TB port-B output crossbar: routes TB read rows onto the RSA B feed and B_cache feed.
// The B path reorders lanes; the cache path passes, transposes tiles, or emits a 2x2 adjugate with its determinant.
//   state   | meaning
//   IDLE    | cache_sel sampled on each valid beat; XFER handled here
//   CAP     | capturing tile rows 1..N-1 (or INV row 1)
//   EMIT    | N output rows, then one drain cycle that zeroes cache_dout
module tb_doutb_xbar #(
    parameter int L      = 4,
    parameter int Y      = 4,
    parameter int RSA_DW = 32,
    parameter int MAX_N  = 4,
    parameter int WIN_W  = 2,
    parameter int OFF_DW = 2
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic [1:0]              b_sel,
    input  logic [OFF_DW-1:0]       b_win_off,
    input  logic [1:0]              cache_sel,
    input  logic [OFF_DW-1:0]       tile_n,
    input  logic                    din_valid,
    input  logic [L*RSA_DW-1:0]     din,
    output logic                    busy,
    output logic [Y*RSA_DW-1:0]     b_dout,
    output logic                    b_valid,
    output logic [Y*RSA_DW-1:0]     cache_dout,
    output logic                    cache_valid,
    output logic [2*RSA_DW-1:0]     det,
    output logic                    det_valid
);

    localparam int CW  = $clog2(MAX_N + 1);
    localparam int IW  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int DW2 = 2 * RSA_DW;

    typedef enum logic [1:0] {ST_IDLE, ST_CAP, ST_EMIT} state_t;

    state_t                    state;
    logic                      inv_mode;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             last;
    logic [IW-1:0]             ci;
    logic signed [RSA_DW-1:0]  lane_in [L];
    logic signed [RSA_DW-1:0]  tile_buf [MAX_N][MAX_N];
    logic [Y*RSA_DW-1:0]       b_next;
    logic [Y*RSA_DW-1:0]       xfer_next;
    logic [Y*RSA_DW-1:0]       emit_next;
    logic                      cap_we;
    logic [IW-1:0]             cap_row;

    assign ci = cnt[IW-1:0];

    always_comb begin
        for (int i = 0; i < L; i++) lane_in[i] = din[i*RSA_DW +: RSA_DW];
    end

    always_comb begin
        int src;
        b_next = '0;
        src    = 0;
        case (b_sel)
            2'b01: for (int i = 0; i < Y; i++) b_next[i*RSA_DW +: RSA_DW] = lane_in[i];
            2'b10: for (int i = 0; i < Y; i++) b_next[i*RSA_DW +: RSA_DW] = lane_in[Y-1-i];
            2'b11: begin
                for (int k = 0; k < WIN_W; k++) begin
                    src = int'(b_win_off) + k;
                    if (src < L) b_next[k*RSA_DW +: RSA_DW] = lane_in[src];
                end
            end
            default: b_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            b_dout  <= '0;
            b_valid <= 1'b0;
        end else begin
            b_valid <= din_valid && (b_sel != 2'b00);
            if (din_valid) b_dout <= b_next;
        end
    end

    always_comb begin
        xfer_next = '0;
        xfer_next[2*RSA_DW-1:0] = din[2*RSA_DW-1:0];
    end

    // INV rows form the adjugate [S22 -S12; -S21 S11]; negation wraps at RSA_DW.
    always_comb begin
        emit_next = '0;
        if (inv_mode) begin
            if (cnt == '0) begin
                emit_next[0 +: RSA_DW]      = tile_buf[1][1];
                emit_next[RSA_DW +: RSA_DW] = -tile_buf[0][1];
            end else begin
                emit_next[0 +: RSA_DW]      = -tile_buf[1][0];
                emit_next[RSA_DW +: RSA_DW] = tile_buf[0][0];
            end
        end else begin
            for (int r = 0; r < MAX_N; r++)
                if (CW'(r) <= last) emit_next[r*RSA_DW +: RSA_DW] = tile_buf[r][ci];
        end
    end

    assign cap_we  = din_valid && (((state == ST_IDLE) && cache_sel[1]) || (state == ST_CAP));
    assign cap_row = (state == ST_IDLE) ? '0 : ci;

    always_ff @(posedge clk) begin
        if (cap_we)
            for (int c = 0; c < MAX_N; c++) tile_buf[cap_row][c] <= lane_in[c];
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            inv_mode    <= 1'b0;
            cnt         <= '0;
            last        <= '0;
            cache_dout  <= '0;
            cache_valid <= 1'b0;
            det         <= '0;
            det_valid   <= 1'b0;
        end else begin
            cache_valid <= 1'b0;
            det_valid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (din_valid) begin
                        case (cache_sel)
                            2'b01: begin
                                cache_dout  <= xfer_next;
                                cache_valid <= 1'b1;
                            end
                            2'b10: begin
                                inv_mode <= 1'b0;
                                last     <= CW'(tile_n);
                                busy     <= 1'b1;
                                if (tile_n == '0) begin
                                    state <= ST_EMIT;
                                    cnt   <= '0;
                                end else begin
                                    state <= ST_CAP;
                                    cnt   <= CW'(1);
                                end
                            end
                            2'b11: begin
                                inv_mode <= 1'b1;
                                last     <= CW'(1);
                                busy     <= 1'b1;
                                state    <= ST_CAP;
                                cnt      <= CW'(1);
                            end
                            default: cache_dout <= '0;
                        endcase
                    end
                end
                ST_CAP: begin
                    if (din_valid) begin
                        if (cnt == last) begin
                            state <= ST_EMIT;
                            cnt   <= '0;
                            if (inv_mode)
                                det <= DW2'(tile_buf[0][0]) * DW2'(lane_in[1])
                                     - DW2'(tile_buf[0][1]) * DW2'(lane_in[0]);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (cnt > last) begin
                        cache_dout <= '0;
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cache_dout  <= emit_next;
                        cache_valid <= 1'b1;
                        det_valid   <= inv_mode && (cnt == '0);
                        cnt         <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb_doutb_xbar.sv
// Directed bench for tb_doutb_xbar: B-path lane modes, XFER, transpose, INV and mid-tile reset.
module tb_tb_doutb_xbar;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [1:0]    b_sel;
    logic [1:0]    b_win_off;
    logic [1:0]    cache_sel;
    logic [1:0]    tile_n;
    logic          din_valid;
    logic [127:0]  din;
    logic          busy;
    logic [127:0]  b_dout;
    logic          b_valid;
    logic [127:0]  cache_dout;
    logic          cache_valid;
    logic [63:0]   det;
    logic          det_valid;

    int errors = 0;
    int checks = 0;
    int busy_cycles;
    logic [63:0] e64;

    tb_doutb_xbar dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .b_sel      (b_sel),
        .b_win_off  (b_win_off),
        .cache_sel  (cache_sel),
        .tile_n     (tile_n),
        .din_valid  (din_valid),
        .din        (din),
        .busy       (busy),
        .b_dout     (b_dout),
        .b_valid    (b_valid),
        .cache_dout (cache_dout),
        .cache_valid(cache_valid),
        .det        (det),
        .det_valid  (det_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] p4(input logic signed [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy) busy_cycles++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; b_sel = 2'b00; b_win_off = '0; cache_sel = 2'b00; tile_n = '0;
        din_valid = 1'b0; din = '0; busy_cycles = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_b_dout", b_dout, '0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cache_dout", cache_dout, '0);
        chk("rst_cache_valid", cache_valid, 0);
        chk("rst_det", det, '0);
        sys_rst = 1'b0;

        b_sel = 2'b01; din = p4(1, 2, 3, 4); din_valid = 1'b1;
        tick();
        chk("pos_dout", b_dout, p4(1, 2, 3, 4));
        chk("pos_valid", b_valid, 1);
        chk("idle_cache_valid", cache_valid, 0);
        b_sel = 2'b10;
        tick();
        chk("neg_dout", b_dout, p4(4, 3, 2, 1));
        din_valid = 1'b0;
        tick();
        chk("hold_valid", b_valid, 0);
        chk("hold_dout", b_dout, p4(4, 3, 2, 1));

        b_sel = 2'b11; b_win_off = 2; din = p4(10, 20, 30, 40); din_valid = 1'b1;
        tick();
        chk("win2_dout", b_dout, p4(30, 40, 0, 0));
        b_win_off = 3;
        tick();
        chk("win3_dout", b_dout, p4(40, 0, 0, 0));
        b_win_off = 0;
        tick();
        chk("win0_dout", b_dout, p4(10, 20, 0, 0));
        b_sel = 2'b00;
        tick();
        chk("bidle_valid", b_valid, 0);
        chk("bidle_dout", b_dout, '0);

        b_sel = 2'b01; cache_sel = 2'b01; din = p4(5, 6, 7, 8);
        tick();
        chk("xfer_cache", cache_dout, p4(5, 6, 0, 0));
        chk("xfer_b", b_dout, p4(5, 6, 7, 8));
        chk("xfer_cvalid", cache_valid, 1);
        chk("xfer_bvalid", b_valid, 1);
        din_valid = 1'b0;
        tick();
        chk("xfer_hold", cache_dout, p4(5, 6, 0, 0));
        chk("xfer_cvalid_lo", cache_valid, 0);

        // N=3 transpose with a stray XFER beat during EMIT and in the drain cycle
        b_sel = 2'b00; cache_sel = 2'b10; tile_n = 2; busy_cycles = 0;
        din = p4(1, 2, 3, 99); din_valid = 1'b1;
        tick();
        chk("tp_busy_cap", busy, 1);
        din = p4(4, 5, 6, 99);
        tick();
        din = p4(7, 8, 9, 99);
        tick();
        chk("tp_no_early", cache_valid, 0);
        cache_sel = 2'b01; din = p4(100, 101, 102, 103);
        tick();
        chk("tp_col0", cache_dout, p4(1, 4, 7, 0));
        chk("tp_col0_v", cache_valid, 1);
        tick();
        chk("tp_col1", cache_dout, p4(2, 5, 8, 0));
        tick();
        chk("tp_col2", cache_dout, p4(3, 6, 9, 0));
        chk("tp_busy_last", busy, 1);
        tick();
        chk("tp_drain_v", cache_valid, 0);
        chk("tp_drain_dout", cache_dout, '0);
        chk("tp_busy_lo", busy, 0);
        chk("tp_busy_cycles", busy_cycles, 6);
        din_valid = 1'b0;

        cache_sel = 2'b11; din = p4(3, 1, 0, 0); din_valid = 1'b1;
        tick();
        din = p4(2, 4, 0, 0);
        tick();
        din_valid = 1'b0;
        chk("inv_det_early", det, 64'd10);
        tick();
        chk("inv_row0", cache_dout, p4(4, -1, 0, 0));
        chk("inv_det_valid", det_valid, 1);
        chk("inv_det", det, 64'd10);
        tick();
        chk("inv_row1", cache_dout, p4(-2, 3, 0, 0));
        chk("inv_det_valid_lo", det_valid, 0);
        tick();
        chk("inv_busy_lo", busy, 0);

        din = p4(-5, 7, 0, 0); din_valid = 1'b1;
        tick();
        din = p4(7, -5, 0, 0);
        tick();
        din_valid = 1'b0;
        tick();
        e64 = -64'sd24;
        chk("invn_det", det, e64);
        chk("invn_row0", cache_dout, p4(-5, -7, 0, 0));
        tick();
        chk("invn_row1", cache_dout, p4(-7, -5, 0, 0));
        tick();
        chk("invn_det_hold", det, e64);

        // async reset between edges while capturing an N=4 tile
        b_sel = 2'b01; cache_sel = 2'b10; tile_n = 3; din = p4(1, 2, 3, 4); din_valid = 1'b1;
        tick();
        din = p4(5, 6, 7, 8);
        tick();
        chk("mid_busy", busy, 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_b_dout", b_dout, '0);
        chk("arst_det", det, '0);
        #1 sys_rst = 1'b0;
        din_valid = 1'b0;

        b_sel = 2'b00; tile_n = 1; din = p4(1, 2, 0, 0); din_valid = 1'b1;
        tick();
        din = p4(3, 4, 0, 0);
        tick();
        din_valid = 1'b0;
        tick();
        chk("n2_col0", cache_dout, p4(1, 3, 0, 0));
        tick();
        chk("n2_col1", cache_dout, p4(2, 4, 0, 0));
        tick();
        chk("n2_busy_lo", busy, 0);

        tile_n = 0; din = p4(42, 0, 0, 0); din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        chk("n1_col0", cache_dout, p4(42, 0, 0, 0));
        tick();
        chk("n1_busy_lo", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tb_doutb_xbar.md
Name: tb_doutb_xbar

Overview:
Parametrised successor to the TB-port output mapper of the systolic-array datapath. It routes TB port-B read data (L lanes) onto the B feed and the B_cache feed (Y lanes each) of the RSA.
- B path: pass, lane reversal, and a programmable window extract.
- B_cache path: pass, a generic N×N tile transpose using an internal buffer, and a 2×2 adjugate/determinant engine for the innovation-covariance inverse.
- Uses a valid/busy handshake instead of being driven by a sequence counter.

Parameters:
L, 4, TB read lanes
Y, 4, RSA input lanes (Y ≤ L)
RSA_DW, 32, signed lane width
MAX_N, 4, largest transpose tile (MAX_N ≤ Y)
WIN_W, 2, window width for B window mode
OFF_DW, 2, width of window offset / tile-size fields

Ports:
clk  in  1  clock
sys_rst  in  1  asynchronous active-high reset
b_sel  in  2  00 IDLE, 01 POS, 10 NEG, 11 WIN
b_win_off  in  OFF_DW  first source lane for WIN
cache_sel  in  2  00 IDLE, 01 XFER, 10 TRANSPOSE, 11 INV
tile_n  in  OFF_DW  transpose tile size minus 1 (N = tile_n+1)
din_valid  in  1  TB_doutb valid this cycle
din  in  L*RSA_DW  TB_doutb row, lane i at [i*RSA_DW +: RSA_DW]
busy  out  1  cache engine capturing/emitting; cache_sel changes ignored
b_dout  out  Y*RSA_DW  B feed
b_valid  out  1  b_dout valid
cache_dout  out  Y*RSA_DW  B_cache feed
cache_valid  out  1  cache_dout valid
det  out  2*RSA_DW  signed S11*S22 − S12*S21, full precision
det_valid  out  1  one-cycle pulse with first INV output row

Behaviour:
- Reset (async, any time including mid-tile): all outputs 0, FSM to IDLE, capture/emit counters 0, buffer contents don't-care.
- Handshake: data is accepted only when din_valid=1. No backpressure. din_valid while busy and emitting is dropped.
- B path is registered, latency 1. b_valid = registered din_valid & (b_sel≠IDLE).
  - IDLE: b_dout ← 0.
  - POS: lane i ← din lane i.
  - NEG: lane i ← din lane Y-1-i.
  - WIN: lanes 0..WIN_W-1 ← din lanes off..off+WIN_W-1; other lanes 0. If a source lane is ≥ L, that output lane is 0.
  - b_dout holds its last value when din_valid=0.
- Cache FSM states: IDLE, CAP, EMIT.
  - In IDLE, cache_sel is sampled on each valid beat.
  - XFER: stays in IDLE; latency 1; lanes 0,1 ← din lanes 0,1; lanes ≥2 ← 0; cache_valid pulses.
  - TRANSPOSE: first valid beat stores row 0 and enters CAP with busy=1. CAP stores rows 1..N-1, lanes 0..N-1, into buf[r][c]. The cycle after row N-1, enters EMIT. For N cycles it outputs column j: lane r ← buf[r][j] for r<N, 0 otherwise, with cache_valid=1. Then returns to IDLE and busy=0. Latency from last row beat to column 0 is 1 cycle. N=1 is legal: 1 capture, 1 emit.
  - INV: captures 2 rows, S11 S12 and S21 S22, from lanes 0,1.
    - On the row-1 beat, registers det = S11*S22 − S12*S21, computed at 2*RSA_DW signed, with no truncation.
    - EMIT, 2 cycles. Row 0 = [S22, −S12]; row 1 = [−S21, S11]. Lanes ≥2 are 0.
    - Negation is two's complement and wraps; −MIN = MIN.
    - det_valid pulses with row 0; det holds its value until the next INV.
  - busy=1 throughout CAP and EMIT. It deasserts in the cycle after the last emitted row.
- Simultaneous events:
  - B path and cache path operate independently on the same din beat.
  - A new cache_sel is taken on the first valid beat after busy falls. A valid beat in the same cycle busy falls is dropped.
- cache_dout returns to 0 in any cycle without cache_valid after EMIT. XFER output holds like b_dout.

Test Plan:
- Reset then POS: din lanes {1,2,3,4} (lane0=1), din_valid=1 → next cycle b_dout lanes {1,2,3,4}, b_valid=1. NEG on same data → {4,3,2,1}.
- WIN with off=2, WIN_W=2: din {10,20,30,40} → b_dout {30,40,0,0}. off=3 → {40,0,0,0}.
- TRANSPOSE N=3: rows {1,2,3,x},{4,5,6,x},{7,8,9,x} on consecutive cycles → busy high 6 cycles. Columns {1,4,7,0},{2,5,8,0},{3,6,9,0} on 3 consecutive cycles starting 1 cycle after row 2. A din beat injected during EMIT is ignored.
- INV: rows {3,1},{2,4} → det=10 with det_valid pulsing alongside row 0 {4,−1,0,0}, then row 1 {−2,3,0,0}. Negative entries {−5,7},{7,−5} → det=−24.
- Async reset asserted mid-CAP of an N=4 transpose, between clock edges → outputs 0 immediately and busy=0. After release, a fresh N=2 tile {1,2},{3,4} emits {1,3},{2,4}.
- XFER and POS together: din {5,6,7,8} → cache_dout {5,6,0,0} and b_dout {5,6,7,8} in the same cycle, both valids 1.
